// File: rtl/if_id_fetch_queue.sv
// IF/ID boundary queue: DEPTH-entry FIFO of {pc, inst} pairs with ready/valid on both sides.
// Decode sees NOP_INST and a zero PC whenever the queue is empty; flush empties it in one cycle.
module if_id_fetch_queue #(
   parameter int unsigned INST_W = 16,
   parameter int unsigned PC_W   = 16,
   parameter int unsigned DEPTH  = 4,
   parameter logic [INST_W-1:0] NOP_INST = '0
) (
   input  logic                        clk_50MHz,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [INST_W-1:0]           in_inst,
   input  logic [PC_W-1:0]             in_pc,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [INST_W-1:0]           out_inst,
   output logic [PC_W-1:0]             out_pc,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = PC_W + INST_W;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   rptr;
   logic [PTR_W-1:0]   wptr;
   logic [ENTRY_W-1:0] head;
   logic               push;
   logic               pop;

   // Handshake flags depend only on the registered count.
   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != CNT_W'(0));

   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   assign head     = mem[rptr];
   assign out_inst = out_valid ? head[INST_W-1:0]       : NOP_INST;
   assign out_pc   = out_valid ? head[ENTRY_W-1:INST_W] : PC_W'(0);

   // Storage carries no reset; only count and pointers define what is valid.
   always_ff @(posedge clk_50MHz) begin
      if (!rst && push) begin
         mem[wptr] <= {in_pc, in_inst};
      end
   end

   always_ff @(posedge clk_50MHz) begin
      if (rst || flush) begin
         count <= CNT_W'(0);
         rptr  <= PTR_W'(0);
         wptr  <= PTR_W'(0);
      end else begin
         if (push) begin
            wptr <= wptr + PTR_W'(1);
         end
         if (pop) begin
            rptr <= rptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_if_id_fetch_queue;

   localparam int unsigned INST_W = 16;
   localparam int unsigned PC_W   = 16;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = 3;

   logic              clk_50MHz = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [INST_W-1:0] in_inst = '0;
   logic [PC_W-1:0]   in_pc = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [INST_W-1:0] out_inst;
   logic [PC_W-1:0]   out_pc;
   logic [CNT_W-1:0]  count;

   logic [31:0] model_q[$];
   int checks = 0;
   int errors = 0;

   always #10 clk_50MHz = ~clk_50MHz;

   if_id_fetch_queue #(
      .INST_W(INST_W), .PC_W(PC_W), .DEPTH(DEPTH), .NOP_INST(16'h0000)
   ) dut (
      .clk_50MHz(clk_50MHz), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .count(count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, compare outputs against the model, then advance the model at the edge.
   task automatic step(input logic r, input logic f, input logic iv,
                       input logic [15:0] ii, input logic [15:0] ip, input logic ordy);
      logic [31:0] exp_head;
      logic        do_push;
      logic        do_pop;
      @(negedge clk_50MHz);
      rst = r; flush = f; in_valid = iv; in_inst = ii; in_pc = ip; out_ready = ordy;
      #1;
      exp_head = (model_q.size() != 0) ? model_q[0] : 32'h0;
      check("count",     32'(count),     32'(model_q.size()));
      check("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
      check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      check("out_inst",  32'(out_inst),  32'(exp_head[15:0]));
      check("out_pc",    32'(out_pc),    32'(exp_head[31:16]));
      do_push = iv && (model_q.size() < DEPTH) && !f;
      do_pop  = ordy && (model_q.size() > 0) && !f;
      @(posedge clk_50MHz);
      if (r || f) begin
         model_q.delete();
      end else begin
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back({ip, ii});
      end
   endtask

   initial begin
      repeat (2) @(posedge clk_50MHz);
      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

      // 1: two pushes, head held while decode stalls
      step(1'b0, 1'b0, 1'b1, 16'h1111, 16'd1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h2222, 16'd2, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      check("t1_count", 32'(count), 32'd2);
      check("t1_head_inst", 32'(out_inst), 32'h1111);
      check("t1_head_pc", 32'(out_pc), 32'd1);

      // 2: fill, rejected fifth offer, drain in order
      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, 16'(i * 16'h1111), 16'(i), 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h5555, 16'd5, 1'b0);
      check("t2_full_count", 32'(count), 32'd4);
      check("t2_in_ready", 32'(in_ready), 32'd0);
      repeat (5) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      check("t2_empty_inst", 32'(out_inst), 32'h0);

      // 3: streaming at count=2 across two pointer wraps
      step(1'b0, 1'b0, 1'b1, 16'hA000, 16'd100, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'hA001, 16'd101, 1'b0);
      for (int i = 2; i < 12; i++) step(1'b0, 1'b0, 1'b1, 16'(16'hA000 + i), 16'(100 + i), 1'b1);
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      check("t3_count", 32'(count), 32'd2);
      check("t3_head_inst", 32'(out_inst), 32'hA00A);

      // 4: flush beats a simultaneous push and pop
      step(1'b0, 1'b0, 1'b1, 16'hB000, 16'd200, 1'b0);
      step(1'b0, 1'b1, 1'b1, 16'hBEEF, 16'd201, 1'b1);
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      check("t4_count", 32'(count), 32'd0);
      check("t4_out_valid", 32'(out_valid), 32'd0);

      // 5: full queue, pop plus offer leaves three entries
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 16'(16'hC000 + i), 16'(300 + i), 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'hC0FF, 16'd399, 1'b1);
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      check("t5_count", 32'(count), 32'd3);
      check("t5_head_inst", 32'(out_inst), 32'hC001);

      // 6: reset mid-stream takes precedence over everything
      step(1'b0, 1'b0, 1'b1, 16'hD000, 16'd400, 1'b1);
      step(1'b1, 1'b1, 1'b1, 16'hD001, 16'd401, 1'b1);
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      check("t6_count", 32'(count), 32'd0);
      check("t6_out_pc", 32'(out_pc), 32'd0);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 50) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
              16'($urandom), 16'($urandom), ($urandom % 3) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
